// File: rtl/mem_port_pkg.sv
// Shared constants and types for the memory port arbiter.
// Holds funct3 encodings, the grant enum and the default starvation limit.
package mem_port_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_D
    } gnt_e;

endpackage

// File: rtl/mem_align_check.sv
// Combinational fault detection for one request channel.
// Flags misalignment, illegal funct3 and illegal store widths.
module mem_align_check
    import mem_port_pkg::*;
(
    input  logic       is_write,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       fault
);

    logic bad_f3;
    logic bad_st;
    logic is_word;
    logic is_half;
    logic mis;

    always_comb begin
        bad_f3  = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                  (funct3 == 3'b111);
        bad_st  = is_write && funct3[2];
        is_word = (funct3[1:0] == LW[1:0]);
        is_half = (funct3[1:0] == LH[1:0]);
        mis     = (is_word && (addr_lo != 2'b00)) ||
                  (is_half && addr_lo[0]);
        fault   = bad_f3 || bad_st || mis;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port.
// Data has priority; a starvation counter forces periodic fetch grants.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_fault,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_write,
    input  logic [2:0]  d_req_funct3,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_fault,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    logic [2:0] starve_q, starve_d;
    logic       rsp_if_q, rsp_if_d;
    logic       rsp_d_q, rsp_d_d;
    logic       rsp_fault_q, rsp_fault_d;
    logic       rsp_rd_q, rsp_rd_d;

    logic       if_fault;
    logic       d_fault;
    logic       force_if;
    gnt_e       gnt;

    mem_align_check u_if_chk (
        .is_write (1'b0),
        .funct3   (LW),
        .addr_lo  (if_addr[1:0]),
        .fault    (if_fault)
    );

    mem_align_check u_d_chk (
        .is_write (d_req_write),
        .funct3   (d_req_funct3),
        .addr_lo  (d_req_addr[1:0]),
        .fault    (d_fault)
    );

    // Readiness depends on the other channel's valid so only one is granted.
    always_comb begin
        force_if     = (starve_q == 3'(STARVE_LIMIT)) && if_req_valid;
        d_req_ready  = !reset && !force_if;
        if_req_ready = !reset && (force_if || !d_req_valid);
        unique case (1'b1)
            d_req_valid && d_req_ready:   gnt = GNT_D;
            if_req_valid && if_req_ready: gnt = GNT_IF;
            default:                      gnt = GNT_NONE;
        endcase
    end

    always_comb begin
        mem_write         = 1'b0;
        mem_funct3        = LW;
        mem_write_address = 32'h0;
        mem_write_data    = 32'h0;
        mem_read_address  = 32'h0;
        unique case (gnt)
            GNT_IF: begin
                if (!if_fault) begin
                    mem_read_address = if_addr;
                end
            end
            GNT_D: begin
                if (!d_fault) begin
                    mem_funct3 = d_req_funct3;
                    if (d_req_write) begin
                        mem_write         = 1'b1;
                        mem_write_address = d_req_addr;
                        mem_write_data    = d_req_wdata;
                    end else begin
                        mem_read_address = d_req_addr;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid || gnt == GNT_IF) begin
            starve_d = 3'd0;
        end else if (gnt == GNT_D) begin
            starve_d = starve_q + 3'd1;
        end
        rsp_if_d    = (gnt == GNT_IF);
        rsp_d_d     = (gnt == GNT_D);
        rsp_fault_d = (rsp_if_d && if_fault) || (rsp_d_d && d_fault);
        rsp_rd_d    = rsp_if_d || (rsp_d_d && !d_req_write);
        rsp_rd_d    = rsp_rd_d && !rsp_fault_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= 3'd0;
            rsp_if_q    <= 1'b0;
            rsp_d_q     <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            rsp_if_q    <= rsp_if_d;
            rsp_d_q     <= rsp_d_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    // Memory returns read data one cycle after the address is presented.
    always_comb begin
        if_rsp_valid = rsp_if_q;
        if_rsp_fault = rsp_if_q && rsp_fault_q;
        if_rsp_data  = (rsp_if_q && rsp_rd_q) ? mem_read_data : 32'h0;
        d_rsp_valid  = rsp_d_q;
        d_rsp_fault  = rsp_d_q && rsp_fault_q;
        d_rsp_data   = (rsp_d_q && rsp_rd_q) ? mem_read_data : 32'h0;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants allowed while a fetch is pending.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports if_req_valid input 1, if_req_ready output 1, if_addr input 32: the instruction-fetch request channel.
REQ-005 SHALL have ports if_rsp_valid output 1, if_rsp_data output 32, if_rsp_fault output 1: the fetch response.
REQ-006 SHALL have ports d_req_valid input 1, d_req_ready output 1, d_req_write input 1, d_req_funct3 input 3, d_req_addr input 32, d_req_wdata input 32: the load/store request channel.
REQ-007 SHALL have ports d_rsp_valid output 1, d_rsp_data output 32, d_rsp_fault output 1: the load/store response.
REQ-008 SHALL have ports mem_write output 1, mem_funct3 output 3, mem_write_address output 32, mem_write_data output 32, mem_read_address output 32, mem_read_data input 32: connection to the memory block.

Function
REQ-009 SHALL grant at most one request per cycle; a request is accepted when valid and ready are both high.
REQ-010 SHALL give d_req priority over if_req, except when the starvation counter equals STARVE_LIMIT and if_req_valid is high; then if_req SHALL be granted.
REQ-011 SHALL increment the 3-bit starvation counter on each data grant while if_req_valid is high, and clear it on any fetch grant or any cycle with if_req_valid low.
REQ-012 SHALL drive the memory port combinationally from the granted request in the accept cycle: fetch -> mem_read_address=if_addr, mem_funct3=3'b010.
REQ-013 SHALL, for a granted load, drive mem_read_address=d_req_addr and mem_funct3=d_req_funct3; for a granted store, drive mem_write=1, mem_write_address=d_req_addr, mem_write_data=d_req_wdata, mem_funct3=d_req_funct3.
REQ-014 SHALL hold mem_write=0, mem_funct3=3'b010, all addresses and write data at 0 in cycles without a valid grant.
REQ-015 SHALL assert the matching rsp_valid for exactly one cycle, the cycle after acceptance (read latency 1); rsp_data = mem_read_data for non-faulting reads, 0 otherwise.
REQ-016 SHALL acknowledge stores with d_rsp_valid=1 and d_rsp_data=0 one cycle after acceptance.
REQ-017 SHALL fault (not issue to memory; mem_write stays 0) on: word access with addr[1:0]!=0; half access with addr[0]!=0; funct3 in {3'b011, 3'b110, 3'b111}; store funct3[2]=1; fetch with if_addr[1:0]!=0.
REQ-018 SHALL report a fault as rsp_valid=1, rsp_fault=1 and rsp_data=0 one cycle after acceptance; rsp_fault SHALL be 0 whenever rsp_valid is 0.
REQ-019 SHALL still accept (ready=1) faulting requests, so a faulting request never stalls.
REQ-020 SHALL NOT apply response back-pressure; the requester SHALL consume responses as they appear.
REQ-021 SHALL allow back-to-back grants every cycle; if_rsp_valid and d_rsp_valid SHALL never be high in the same cycle.

Reset
REQ-022 SHALL, while reset is high, force if_req_ready=0, d_req_ready=0, mem_write=0, and clear the starvation counter and pending-response registers.
REQ-023 SHALL hold all response outputs at 0 in the cycle after reset; a read accepted in the cycle reset rises SHALL produce no response.

Structure
REQ-024 SHALL place funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW), the grant enum (GNT_NONE/GNT_IF/GNT_D) and the STARVE_LIMIT default in package mem_port_pkg.
REQ-025 SHALL implement fault detection as one combinational sub-module, mem_align_check, instantiated once for each request channel.

Verification
REQ-026 Load: memory word 0x00000100=0x8899AABB, lbu at 0x101 -> d_rsp_valid next cycle, d_rsp_data=0x000000AA, fault 0.
REQ-027 Contention: if_req and d_req (lw 0x200) held valid every cycle -> four data grants, then one fetch grant, with the pattern repeating; no cycle has both rsp_valid.
REQ-028 Store then read: sh 0x1234 to 0x202, then lw 0x200 (prior 0) -> store ack with data 0, then d_rsp_data=0x12340000.
REQ-029 Misaligned: lw at 0x00000006 -> mem_write=0, d_rsp_valid=1, d_rsp_fault=1, data 0 next cycle; fetch at 0x2 -> if_rsp_fault=1.
REQ-030 Reset mid-read: fetch accepted in the cycle reset rises -> if_rsp_valid stays 0; after reset deasserts, the first grant behaves normally.
REQ-031 Peripheral: lw 0xFFFFFFF8 twice, 12000 cycles apart -> the second value exceeds the first by 1.
